// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC BRAM unpack reader.
package adc_pkg;
  localparam int unsigned SAMPLE_W   = 14;
  localparam int unsigned LANE_W     = 16;
  localparam int unsigned LANES      = 4;
  localparam int unsigned ADDR_W_DEF = 14;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    UNPACK
  } rd_state_t;
endpackage

// File: rtl/gray_ptr_sync.sv
// Brings the Gray-coded write pointer into the read clock domain and
// converts it to binary.
module gray_ptr_sync #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              i_50clk,
  input  logic              i_nreset,
  input  logic [ADDR_W-1:0] i_ptr_gray,
  output logic [ADDR_W-1:0] o_ptr_bin
);
  logic [ADDR_W-1:0] sync_q [SYNC_STAGES];

  // Synchronizer chain; only one Gray bit changes per write so each stage is safe.
  always_ff @(posedge i_50clk or negedge i_nreset) begin
    if (!i_nreset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= i_ptr_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    o_ptr_bin = '0;
    for (int unsigned i = 0; i < ADDR_W; i++)
      o_ptr_bin[i] = ^(sync_q[SYNC_STAGES-1] >> i);
  end
endmodule

// File: rtl/adc_unpack_reader.sv
// Reads 64-bit words from the ADC capture BRAM and streams out the four
// 14-bit samples of each word, one per accepted handshake.
module adc_unpack_reader
  import adc_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                i_50clk,
  input  logic                i_nreset,
  input  logic [ADDR_W-1:0]   i_wr_ptr_gray,
  input  logic                i_enable,
  output logic [ADDR_W-1:0]   o_rdaddress,
  input  logic [63:0]         i_q,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic [1:0]          o_lane,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [ADDR_W-1:0]   o_level,
  output logic                o_overrun
);
  localparam int unsigned CNT_W = $clog2(RD_LATENCY + 2);

  rd_state_t                          state, state_nxt;
  logic [ADDR_W-1:0]                  wr_bin, rd_ptr, level_q, rdaddr_q;
  logic [CNT_W-1:0]                   cnt;
  logic [1:0]                         lane;
  logic [LANES-1:0][SAMPLE_W-1:0]     hold;
  logic                               overrun_q;
  logic                               issue, capture, advance;
  logic                               unused_guard_bits;

  gray_ptr_sync #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_50clk    (i_50clk),
    .i_nreset   (i_nreset),
    .i_ptr_gray (i_wr_ptr_gray),
    .o_ptr_bin  (wr_bin)
  );

  // Next-state decode: when to launch a read, capture data and step lanes.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable && level_q != '0) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = UNPACK;
        end
      end
      UNPACK: begin
        if (i_ready) begin
          if (lane != 2'(LANES - 1)) begin
            advance = 1'b1;
          end else if (i_enable && level_q > ADDR_W'(1)) begin
            issue     = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointers, hold register and status flags.
  always_ff @(posedge i_50clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      rdaddr_q  <= '0;
      level_q   <= '0;
      cnt       <= '0;
      lane      <= '0;
      hold      <= '0;
      overrun_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      level_q <= wr_bin - rd_ptr;
      if (issue) begin
        rdaddr_q <= rd_ptr;
        cnt      <= CNT_W'(RD_LATENCY);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        for (int unsigned i = 0; i < LANES; i++)
          hold[i] <= i_q[LANE_W*i +: SAMPLE_W];
        rd_ptr <= rd_ptr + 1'b1;
        lane   <= '0;
      end else if (advance) begin
        lane <= lane + 1'b1;
      end
      if (!i_enable)
        overrun_q <= 1'b0;
      else if (level_q == '1)
        overrun_q <= 1'b1;
    end
  end

  // Guard bits [15:14] of every lane carry no sample data.
  always_comb begin
    unused_guard_bits = 1'b0;
    for (int unsigned i = 0; i < LANES; i++)
      unused_guard_bits = unused_guard_bits ^ (^i_q[LANE_W*i+SAMPLE_W +: LANE_W-SAMPLE_W]);
  end

  assign o_valid     = (state == UNPACK);
  assign o_sample    = hold[lane];
  assign o_lane      = lane;
  assign o_rdaddress = rdaddr_q;
  assign o_level     = level_q;
  assign o_overrun   = overrun_q;
endmodule
